// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared raster timing defaults, counter widths and scan FSM encoding
package frame_pkg;

    localparam int H_ACTIVE_DEF = 400;
    localparam int H_FP_DEF     = 20;
    localparam int H_SYNC_DEF   = 64;
    localparam int H_BP_DEF     = 44;

    localparam int V_ACTIVE_DEF = 225;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 17;

    localparam bit SYNC_POL_DEF = 1'b0;

    // Counter widths hold the full line/frame period; read addresses are narrower
    // because only the visible window is ever presented to the frame buffer.
    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 9;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_ALIGN     = 2'd1,
        ST_SCAN      = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_timing_gen.sv
// rtl/scan_timing_gen.sv - horizontal/vertical raster counters with raw window and sync flags
module scan_timing_gen
    import frame_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_tick,
    input  logic           i_run,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_in_window,
    output logic           o_hsync_act,
    output logic           o_vsync_act,
    output logic           o_origin,
    output logic           o_last
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_BEG = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_BEG = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster counters: held at the origin while idle, one pixel per enabled tick otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!i_run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign o_x         = h_cnt[X_W-1:0];
    assign o_y         = v_cnt[Y_W-1:0];
    assign o_in_window = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign o_hsync_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign o_vsync_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign o_origin    = (h_cnt == '0) && (v_cnt == '0);
    assign o_last      = h_wrap && v_wrap;

endmodule

// File: rtl/frame_scan_reader.sv
// rtl/frame_scan_reader.sv - raster scan of the frame buffer with sync generation and colour split
module frame_scan_reader
    import frame_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_en,
    input  logic           i_init_done,
    output logic [X_W-1:0] o_rd_x,
    output logic [Y_W-1:0] o_rd_y,
    output logic           o_rd_en,
    input  logic [5:0]     i_rd_data,
    output logic [1:0]     o_r,
    output logic [1:0]     o_g,
    output logic [1:0]     o_b,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic           o_frame_start
);

    scan_state_t    state_q;
    scan_state_t    state_d;
    logic           run;
    logic           scanning;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic           in_window;
    logic           hsync_act;
    logic           vsync_act;
    logic           origin;
    logic           last;
    logic           rd_en;
    logic [X_W-1:0] x_hold;
    logic [Y_W-1:0] y_hold;
    logic           de_q;
    logic           hs_q;
    logic           vs_q;
    logic           fs_q;

    assign run      = (state_q != ST_WAIT_INIT);
    assign scanning = (state_q == ST_SCAN);

    scan_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_tick      (i_pix_en),
        .i_run       (run),
        .o_x         (cur_x),
        .o_y         (cur_y),
        .o_in_window (in_window),
        .o_hsync_act (hsync_act),
        .o_vsync_act (vsync_act),
        .o_origin    (origin),
        .o_last      (last)
    );

    // Scan FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave idle on the first enabled tick with init done; scanning only ever begins at the
    // raster origin, and once scanning a falling init_done is ignored so frames are never torn
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_INIT: if (i_pix_en && i_init_done) state_d = origin ? ST_SCAN : ST_ALIGN;
            ST_ALIGN:     if (i_pix_en && last)        state_d = ST_SCAN;
            ST_SCAN:      state_d = ST_SCAN;
            default:      state_d = ST_WAIT_INIT;
        endcase
    end

    assign rd_en = scanning && in_window;

    // Keep the last in-window address so the read port stays quiet during blanking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (rd_en) begin
            x_hold <= cur_x;
            y_hold <= cur_y;
        end
    end

    assign o_rd_en = rd_en;
    assign o_rd_x  = rd_en ? cur_x : x_hold;
    assign o_rd_y  = rd_en ? cur_y : y_hold;

    // Delay display timing by one pixel tick so it lines up with the returning read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (i_pix_en) begin
            de_q <= rd_en;
            hs_q <= scanning && hsync_act;
            vs_q <= scanning && vsync_act;
            fs_q <= scanning && origin;
        end
    end

    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_hsync       = hs_q ? SYNC_POL : ~SYNC_POL;
    assign o_vsync       = vs_q ? SYNC_POL : ~SYNC_POL;
    assign o_r           = de_q ? i_rd_data[5:4] : 2'b00;
    assign o_g           = de_q ? i_rd_data[3:2] : 2'b00;
    assign o_b           = de_q ? i_rd_data[1:0] : 2'b00;

endmodule

// File: tb/tb_frame_scan_reader.sv
// tb/tb_frame_scan_reader.sv - scoreboard bench for the frame scan reader on a reduced raster
module tb_frame_scan_reader;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = 8;
    localparam int FRAME = HT * VT;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_pix_en = 1'b0;
    logic       i_init_done = 1'b0;
    logic [5:0] i_rd_data = 6'h2a;
    logic [8:0] o_rd_x;
    logic [7:0] o_rd_y;
    logic       o_rd_en;
    logic [1:0] o_r;
    logic [1:0] o_g;
    logic [1:0] o_b;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_de;
    logic       o_frame_start;

    typedef struct {
        int         x;
        int         y;
        int         off;
        logic [5:0] rgb;
    } pix_t;

    pix_t exp_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic en_at_edge = 1'b0;
    bit   idle_chk = 1'b0;
    bit   const_mode = 1'b1;
    bit   toggle_en = 1'b0;
    int   stretch = 1;

    frame_scan_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pix_en      (i_pix_en),
        .i_init_done   (i_init_done),
        .o_rd_x        (o_rd_x),
        .o_rd_y        (o_rd_y),
        .o_rd_en       (o_rd_en),
        .i_rd_data     (i_rd_data),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_de          (o_de),
        .o_frame_start (o_frame_start)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] pat(input int x, input int y);
        int t;
        t = x * 7 + y * 13 + 5;
        return t[5:0];
    endfunction

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic push_frames(input int nframes, input bit cmode);
        for (int f = 0; f < nframes; f++) begin
            for (int y = 0; y < VA; y++) begin
                for (int x = 0; x < HA; x++) begin
                    pix_t e;
                    e.x   = x;
                    e.y   = y;
                    e.off = f * FRAME + y * HT + x;
                    e.rgb = cmode ? {2'd3, 2'd1, 2'd2} : pat(x, y);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        i_rst_n = 1'b0;
        i_init_done = 1'b0;
        step();
        step();
        exp_q.delete();
        i_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, o_rd_en, 0);
        chk({tag, "_rd_xy"}, {o_rd_x, o_rd_y}, 0);
        chk({tag, "_de_fs"}, {o_de, o_frame_start}, 0);
        chk({tag, "_syncs"}, {o_hsync, o_vsync}, 2'b11);
        chk({tag, "_rgb"}, {o_r, o_g, o_b}, 0);
    endtask

    // Edge bookkeeping: cycle counter and whether the last rising edge was a pixel tick
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        en_at_edge <= i_pix_en;
    end

    // Pixel-enable toggler for the stretched-timing phase
    always @(posedge i_clk) begin
        if (toggle_en) begin
            #2;
            i_pix_en = ~i_pix_en;
        end
    end

    // Frame-buffer model: answers a read one pixel tick later, holds data on idle ticks
    logic mem_en;
    int   mem_x;
    int   mem_y;
    always @(negedge i_clk) begin
        mem_en = o_rd_en;
        mem_x  = o_rd_x;
        mem_y  = o_rd_y;
    end
    always @(posedge i_clk) begin
        if (i_pix_en) begin
            #1;
            if (const_mode)  i_rd_data = 6'b110110;
            else if (mem_en) i_rd_data = pat(mem_x, mem_y);
            else             i_rd_data = 6'h2a;
        end
    end

    // Monitor: pops expected pixels on displayed ticks, checks blanking, sync timing and holds
    logic [27:0] prev_v;
    bit          have_prev = 1'b0;
    bit          sync_run = 1'b0;
    int          k = 0;
    int          base_cyc = 0;
    always @(negedge i_clk) begin
        logic [27:0] cur_v;
        pix_t        e;
        int          h;
        int          v;
        cur_v = {o_rd_en, o_rd_x, o_rd_y, o_de, o_hsync, o_vsync, o_frame_start, o_r, o_g, o_b};
        if (!i_rst_n) begin
            have_prev = 1'b0;
            sync_run  = 1'b0;
        end else begin
            if (idle_chk) chk("idle_outputs", {o_rd_en, o_de, o_hsync, o_vsync}, 4'b0011);
            if (!en_at_edge) begin
                if (have_prev) chk("hold_on_pix_en_low", cur_v, prev_v);
            end else begin
                if (o_de) begin
                    chk("pix_available", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        if (e.off == 0) base_cyc = cyc;
                        chk("rgb", {o_r, o_g, o_b}, e.rgb);
                        chk("frame_start_at_origin", o_frame_start, (e.x == 0 && e.y == 0));
                        chk("pixel_cycle_offset", cyc - base_cyc, e.off * stretch);
                    end
                end else begin
                    chk("blank_rgb_fs", {o_r, o_g, o_b, o_frame_start}, 0);
                end
                if (o_frame_start && !sync_run) begin
                    sync_run = 1'b1;
                    k = 0;
                end
                if (sync_run) begin
                    h = k % HT;
                    v = (k / HT) % VT;
                    chk("sync_de_timing", {o_hsync, o_vsync, o_de},
                        {!(h >= HA + HF && h < HA + HF + HS),
                         !(v >= VA + VF && v < VA + VF + VS),
                         (h < HA && v < VA)});
                    k++;
                end
            end
            prev_v    = cur_v;
            have_prev = 1'b1;
        end
    end

    initial begin
        bit found;

        // Reset state, asserted asynchronously before any clock edge
        #1 i_rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge i_clk);
        #2;

        // Idle: init not done, nothing may be read or displayed
        i_pix_en = 1'b1;
        i_rst_n  = 1'b1;
        idle_chk = 1'b1;
        repeat (200) step();

        // Constant data, two frames; init_done drops mid-scan and must be ignored
        const_mode = 1'b1;
        stretch    = 1;
        push_frames(2, 1'b1);
        i_init_done = 1'b1;
        idle_chk    = 1'b0;
        step();
        chk("first_read_en", o_rd_en, 1);
        chk("first_read_xy", {o_rd_x, o_rd_y}, 0);
        chk("first_read_de_low", o_de, 0);
        step();
        chk("first_frame_start", o_frame_start, 1);
        chk("first_de", o_de, 1);
        repeat (40) step();
        i_init_done = 1'b0;
        drain(2 * FRAME + 40);
        reset_dut();

        // Pixel enable toggling every cycle: all timing stretched by two, holds in between
        const_mode = 1'b0;
        stretch    = 2;
        idle_chk   = 1'b1;
        toggle_en  = 1'b1;
        repeat (20) step();
        push_frames(1, 1'b0);
        i_init_done = 1'b1;
        idle_chk    = 1'b0;
        drain(2 * FRAME + 40);
        toggle_en = 1'b0;
        step();
        i_pix_en = 1'b1;
        reset_dut();

        // Reset in the middle of a frame, then a clean restart from the origin
        stretch  = 1;
        idle_chk = 1'b1;
        repeat (10) step();
        push_frames(1, 1'b0);
        i_init_done = 1'b1;
        idle_chk    = 1'b0;
        step();
        chk("scan_read_xy", {o_rd_en, o_rd_x, o_rd_y}, {1'b1, 17'd0});
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (o_rd_en && o_rd_x == 9'd5 && o_rd_y == 8'd2) found = 1'b1;
        end
        chk("reached_pixel_5_2", found, 1);
        #1 i_rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        i_init_done = 1'b0;
        step();
        step();
        i_rst_n  = 1'b1;
        idle_chk = 1'b1;
        repeat (20) step();
        push_frames(1, 1'b0);
        i_init_done = 1'b1;
        idle_chk    = 1'b0;
        step();
        chk("restart_read_en", o_rd_en, 1);
        chk("restart_read_xy", {o_rd_x, o_rd_y}, 0);
        drain(FRAME + 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
